// File: rtl/lpm_arbiter.sv
// lpm_arbiter: shares one Lpm lookup engine between NREQ requesters and a table-write port.
// Define LPM_ARB_ROUND_ROBIN_EN for round-robin grant; otherwise the lowest valid index wins.
module lpm_arbiter #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 8,
  parameter int DW    = 32,
  parameter int AW    = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NREQ-1:0]            req_enter__ENA,
  input  logic [NREQ*DW-1:0]         req_enter_x,
  output logic [NREQ-1:0]            req_enter__RDY,
  input  logic                       cfg_write__ENA,
  input  logic [AW-1:0]              cfg_write_addr,
  input  logic [DW-1:0]              cfg_write_data,
  output logic                       cfg_write__RDY,
  output logic                       lpm_enter__ENA,
  output logic [DW-1:0]              lpm_enter_x,
  input  logic                       lpm_enter__RDY,
  output logic                       lpm_write__ENA,
  output logic [AW-1:0]              lpm_write_addr,
  output logic [DW-1:0]              lpm_write_data,
  input  logic                       lpm_write__RDY,
  input  logic                       lpm_out__ENA,
  input  logic [DW-1:0]              lpm_out_v,
  output logic                       lpm_out__RDY,
  output logic [NREQ-1:0]            rsp_out__ENA,
  output logic [DW-1:0]              rsp_out_v,
  input  logic [NREQ-1:0]            rsp_out__RDY,
  output logic [$clog2(DEPTH+1)-1:0] outstanding
);
  localparam int IW = $clog2(NREQ);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {RUN, DRAIN, WRITE} state_t;

  state_t          state;
  logic [NREQ-1:0] slot_valid;
  logic [DW-1:0]   slot_key [NREQ];
  logic            wr_valid;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [IW-1:0]   tag_mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [OW-1:0]   count;

  logic [NREQ-1:0] req_fire;
  logic            cfg_fire;
  logic            issue;
  logic            pop;
  logic [IW-1:0]   start;
  logic [IW-1:0]   grant;
  logic [IW-1:0]   head;

  // First valid slot at or after 'start', scanning upward with wrap.
  function automatic logic [IW-1:0] pick(input logic [NREQ-1:0] v, input logic [IW-1:0] from);
    logic [IW-1:0] idx;
    logic          found;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'((int'(from) + k) % NREQ);
      if (!found && v[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  assign req_fire = req_enter__ENA & ~slot_valid;
  assign cfg_fire = cfg_write__ENA & ~wr_valid;
  assign grant    = pick(slot_valid, start);
  assign head     = tag_mem[rd_ptr];

  assign issue = !RST && (state == RUN) && !wr_valid && (|slot_valid) &&
                 (count < OW'(DEPTH)) && lpm_enter__RDY;
  assign pop   = !RST && lpm_out__ENA && (count != '0);

  assign req_enter__RDY = RST ? '0 : ~slot_valid;
  assign cfg_write__RDY = !RST && !wr_valid;
  assign lpm_enter__ENA = issue;
  assign lpm_enter_x    = slot_key[grant];
  assign lpm_write__ENA = !RST && (state == WRITE) && lpm_write__RDY;
  assign lpm_write_addr = wr_addr;
  assign lpm_write_data = wr_data;
  assign lpm_out__RDY   = !RST && (count != '0) && rsp_out__RDY[head];
  assign rsp_out__ENA   = pop ? (NREQ'(1) << head) : '0;
  assign rsp_out_v      = lpm_out_v;
  assign outstanding    = count;

`ifdef LPM_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] rr_ptr;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
    end
  end

  assign start = rr_ptr;
`else
  assign start = '0;
`endif

  // Control: slot/write valid bits, tag FIFO pointers, in-flight count and the drain FSM.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      slot_valid <= '0;
      wr_valid   <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      state      <= RUN;
    end else begin
      if (issue) slot_valid[grant] <= 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (req_fire[i]) slot_valid[i] <= 1'b1;
      end

      if (cfg_fire) wr_valid <= 1'b1;
      else if (lpm_write__ENA) wr_valid <= 1'b0;

      if (issue) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;

      case ({issue, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      case (state)
        RUN:     if (wr_valid || cfg_fire) state <= DRAIN;
        DRAIN:   if (count == '0) state <= WRITE;
        WRITE:   if (lpm_write__ENA) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Data: keys, pending write and tags only load under their own enables.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NREQ; i++) begin
      if (req_fire[i]) slot_key[i] <= req_enter_x[i*DW +: DW];
    end
    if (cfg_fire) begin
      wr_addr <= cfg_write_addr;
      wr_data <= cfg_write_data;
    end
    if (issue) tag_mem[wr_ptr] <= grant;
  end

endmodule
